// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and default parameters for the memory bus master.
//   state_t       FSM state encoding (IDLE, REQ, XFER, HOLD)
//   DEF_*         default widths and hold length used by the interface and RTL
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LEN_W    = 3;
    localparam int DEF_HOLD_CYC = 5;

endpackage

// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: command handshake, local data path and arbitrated bus
// signals of mem_bus_master, bundled together.
//   master modport  - seen from mem_bus_master (drives cmd_ready, bus_*, rd_*)
//   slave modport   - seen from the command source / bus side
interface mem_bus_master_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
);
    // command side
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    // memory bus side
    logic              bus_req;
    logic              bus_grant;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_addr_oe;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data,
        input  bus_grant, bus_rdata,
        output cmd_ready, wr_ready, rd_data, rd_valid, done,
        output bus_req, bus_addr, bus_addr_oe, bus_we, bus_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data,
        output bus_grant, bus_rdata,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done,
        input  bus_req, bus_addr, bus_addr_oe, bus_we, bus_wdata
    );

endinterface

// File: rtl/mem_bus_hold_timer.sv
// mem_bus_hold_timer: down-counter timing the post-burst address/request hold.
//   clk, rst_n  clock and asynchronous active-low reset
//   load        loads HOLD_CYC-1; asserted on the cycle of the last beat
//   expire      terminal count (counter at zero); marks the final HOLD cycle
module mem_bus_hold_timer
    import mem_bus_pkg::*;
#(
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    localparam int CNT_W  = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    // Loading HOLD_CYC-1 makes the zero-count cycle the last of HOLD_CYC cycles.
    localparam int LOAD_I = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_I);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: turns a read/write burst command into a request/grant bus
// transaction, one beat per granted cycle, then holds address and request for
// HOLD_CYC cycles before releasing the bus.
//   clk, rst_n  clock and asynchronous active-low reset
//   bif         mem_bus_master_if.master: command handshake (cmd_*), write data
//               (wr_data/wr_ready), read data (rd_data/rd_valid), done pulse,
//               and the arbitrated bus (bus_req/grant/addr/addr_oe/we/wdata/rdata)
//
// state | meaning
// IDLE  | cmd_ready high, waiting for cmd_valid
// REQ   | bus_req high, waiting for first grant
// XFER  | address driven, one beat per granted cycle
// HOLD  | last address and request held for HOLD_CYC cycles, grant ignored
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input logic           clk,
    input logic           rst_n,
    mem_bus_master_if.master bif
);
    state_t            state;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;

    logic              cmd_ready_q;
    logic              bus_req_q;
    logic              bus_addr_oe_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              done_q;

    logic              beat_now;
    logic              last_beat;
    logic              hold_expire;

    assign beat_now  = (state == XFER) && bif.bus_grant;
    assign last_beat = beat_now && (beat_q == len_q);

    mem_bus_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (last_beat),
        .expire (hold_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            write_q       <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            cmd_ready_q   <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_addr_oe_q <= 1'b0;
            bus_addr_q    <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bif.cmd_valid && cmd_ready_q) begin
                        write_q     <= bif.cmd_write;
                        addr_q      <= bif.cmd_addr;
                        len_q       <= bif.cmd_len;
                        beat_q      <= '0;
                        cmd_ready_q <= 1'b0;
                        bus_req_q   <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bif.bus_grant) begin
                        bus_addr_oe_q <= 1'b1;
                        bus_addr_q    <= addr_q;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (bif.bus_grant) begin
                        if (!write_q) begin
                            rd_data_q  <= bif.bus_rdata;
                            rd_valid_q <= 1'b1;
                        end
                        if (beat_q == len_q) begin
                            if (HOLD_CYC == 0) begin
                                bus_req_q     <= 1'b0;
                                bus_addr_oe_q <= 1'b0;
                                bus_addr_q    <= '0;
                                cmd_ready_q   <= 1'b1;
                                done_q        <= 1'b1;
                                state         <= IDLE;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            beat_q <= beat_q + LEN_W'(1);
                            // base + beat, truncated so the address wraps
                            bus_addr_q <= addr_q + ADDR_W'(beat_q + LEN_W'(1));
                        end
                    end
                end
                HOLD: begin
                    if (hold_expire) begin
                        bus_req_q     <= 1'b0;
                        bus_addr_oe_q <= 1'b0;
                        bus_addr_q    <= '0;
                        cmd_ready_q   <= 1'b1;
                        done_q        <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bif.cmd_ready   = cmd_ready_q;
    assign bif.bus_req     = bus_req_q;
    assign bif.bus_addr_oe = bus_addr_oe_q;
    assign bif.bus_addr    = bus_addr_q;
    assign bif.rd_data     = rd_data_q;
    assign bif.rd_valid    = rd_valid_q;
    assign bif.done        = done_q;

    // Write strobe and data follow the grant in the same cycle.
    assign bif.bus_we      = beat_now && write_q;
    assign bif.wr_ready    = beat_now && write_q;
    assign bif.bus_wdata   = (beat_now && write_q) ? bif.wr_data : '0;

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

    localparam logic [31:0] WD_BASE = 32'hC0DE_0000;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_bus_master_if #(.ADDR_W(16), .DATA_W(32), .LEN_W(3)) bif ();
    mem_bus_master_if #(.ADDR_W(16), .DATA_W(32), .LEN_W(3)) bif0 ();

    mem_bus_master #(.ADDR_W(16), .DATA_W(32), .LEN_W(3), .HOLD_CYC(5)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    mem_bus_master #(.ADDR_W(16), .DATA_W(32), .LEN_W(3), .HOLD_CYC(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif0)
    );

    // shared stimulus; sel_q picks which DUT receives cmd_valid and is observed
    logic        sel_q;
    logic        cv;
    logic        cw;
    logic [15:0] ca;
    logic [2:0]  cl;
    logic        gnt;
    logic [31:0] wdat;
    logic [31:0] rdat;

    assign bif.cmd_valid  = cv & ~sel_q;
    assign bif0.cmd_valid = cv & sel_q;
    assign bif.cmd_write  = cw;
    assign bif0.cmd_write = cw;
    assign bif.cmd_addr   = ca;
    assign bif0.cmd_addr  = ca;
    assign bif.cmd_len    = cl;
    assign bif0.cmd_len   = cl;
    assign bif.bus_grant  = gnt;
    assign bif0.bus_grant = gnt;
    assign bif.wr_data    = wdat;
    assign bif0.wr_data   = wdat;
    assign bif.bus_rdata  = rdat;
    assign bif0.bus_rdata = rdat;

    logic        m_rdy, m_req, m_oe, m_we, m_wrr, m_rdv, m_done;
    logic [15:0] m_addr;
    logic [31:0] m_rd, m_wd;

    assign m_rdy  = sel_q ? bif0.cmd_ready   : bif.cmd_ready;
    assign m_req  = sel_q ? bif0.bus_req     : bif.bus_req;
    assign m_oe   = sel_q ? bif0.bus_addr_oe : bif.bus_addr_oe;
    assign m_we   = sel_q ? bif0.bus_we      : bif.bus_we;
    assign m_wrr  = sel_q ? bif0.wr_ready    : bif.wr_ready;
    assign m_rdv  = sel_q ? bif0.rd_valid    : bif.rd_valid;
    assign m_done = sel_q ? bif0.done        : bif.done;
    assign m_addr = sel_q ? bif0.bus_addr    : bif.bus_addr;
    assign m_rd   = sel_q ? bif0.rd_data     : bif.rd_data;
    assign m_wd   = sel_q ? bif0.bus_wdata   : bif.bus_wdata;

    // per-cycle traces, index = cycles after the accept cycle T
    logic [15:0] tr_rdy, tr_req, tr_oe, tr_we, tr_wrr, tr_rdv, tr_done;
    logic [15:0] tr_addr [16];
    logic [31:0] tr_rd   [16];
    logic [31:0] tr_wd   [16];

    int n_chk;
    int n_bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic rec(input int i);
        tr_rdy[i]  = m_rdy;
        tr_req[i]  = m_req;
        tr_oe[i]   = m_oe;
        tr_we[i]   = m_we;
        tr_wrr[i]  = m_wrr;
        tr_rdv[i]  = m_rdv;
        tr_done[i] = m_done;
        tr_addr[i] = m_addr;
        tr_rd[i]   = m_rd;
        tr_wd[i]   = m_wd;
    endtask

    // Waits (bounded) for cmd_ready, issues one command, records 16 cycles.
    // rdat in cycle i is rbase + i - 2, so an unstalled beat k returns rbase + k.
    task automatic run_txn(input logic s, input logic w, input logic [15:0] a,
                           input logic [2:0] l, input logic [15:0] gpat,
                           input logic [31:0] rbase, input logic b2b,
                           input logic [15:0] a2);
        int  wb;
        int  guard;
        logic sent;
        wb    = 0;
        guard = 0;
        sent  = 1'b0;
        sel_q = s;
        cv    = 1'b0;
        @(negedge clk); #1;
        while (!m_rdy && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("ready_wait", {63'd0, m_rdy}, 64'd1);
        if (!m_rdy) return;
        cv   = 1'b1;
        cw   = w;
        ca   = a;
        cl   = l;
        gnt  = gpat[0];
        wdat = WD_BASE;
        rdat = rbase - 32'd2;
        #1;
        rec(0);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            cv   = 1'b0;
            gnt  = gpat[i];
            wdat = WD_BASE + 32'(wb);
            rdat = rbase + 32'(i) - 32'd2;
            if (b2b && !sent && m_done && m_rdy) begin
                cv   = 1'b1;
                ca   = a2;
                sent = 1'b1;
            end
            #1;
            rec(i);
            if (m_wrr) wb++;
        end
        cv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        sel_q = 1'b0;
        cv    = 1'b0;
        cw    = 1'b0;
        ca    = '0;
        cl    = '0;
        gnt   = 1'b0;
        wdat  = '0;
        rdat  = '0;
        rst_n = 1'b0;

        // reset state of both builds
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flags", {57'd0, bif.cmd_ready, bif.bus_req, bif.bus_addr_oe, bif.bus_we,
                          bif.wr_ready, bif.rd_valid, bif.done}, 64'd0);
        chk("rst_data", {bif.rd_data, bif.bus_addr, bif.bus_wdata[15:0]}, 64'd0);
        chk("rst_flags0", {57'd0, bif0.cmd_ready, bif0.bus_req, bif0.bus_addr_oe, bif0.bus_we,
                           bif0.wr_ready, bif0.rd_valid, bif0.done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_clk", {63'd0, bif.cmd_ready}, 64'd0);
        @(negedge clk); #1;
        chk("rdy_after_clk", {63'd0, bif.cmd_ready}, 64'd1);

        // single read, grant tied high
        run_txn(1'b0, 1'b0, 16'h0010, 3'd0, 16'hFFFF, 32'hDEADBEEF, 1'b0, 16'h0);
        chk("rd1_req",   {48'd0, tr_req},  64'h00FE);
        chk("rd1_oe",    {48'd0, tr_oe},   64'h00FC);
        chk("rd1_rdv",   {48'd0, tr_rdv},  64'h0008);
        chk("rd1_done",  {48'd0, tr_done}, 64'h0100);
        chk("rd1_rdy",   {48'd0, tr_rdy},  64'hFF01);
        chk("rd1_we",    {48'd0, tr_we},   64'h0000);
        chk("rd1_data",  {32'd0, tr_rd[3]}, 64'hDEADBEEF);
        chk("rd1_addr",  {48'd0, tr_addr[2]}, 64'h0010);

        // write burst of 4
        run_txn(1'b0, 1'b1, 16'h0100, 3'd3, 16'hFFFF, 32'h0, 1'b0, 16'h0);
        chk("wr_we",   {48'd0, tr_we},   64'h003C);
        chk("wr_wrr",  {48'd0, tr_wrr},  64'h003C);
        chk("wr_req",  {48'd0, tr_req},  64'h07FE);
        chk("wr_oe",   {48'd0, tr_oe},   64'h07FC);
        chk("wr_done", {48'd0, tr_done}, 64'h0800);
        chk("wr_rdv",  {48'd0, tr_rdv},  64'h0000);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wr_addr%0d", k), {48'd0, tr_addr[2+k]}, 64'h0100 + 64'(k));
            chk($sformatf("wr_wdata%0d", k), {32'd0, tr_wd[2+k]}, {32'd0, WD_BASE} + 64'(k));
        end
        chk("wr_hold_addr",  {48'd0, tr_addr[6]}, 64'h0103);
        chk("wr_hold_wdata", {32'd0, tr_wd[6]},   64'h0);

        // read burst of 4 with grant low in cycles 3 and 4
        run_txn(1'b0, 1'b0, 16'h0200, 3'd3, 16'hFFE7, 32'h1000_0000, 1'b0, 16'h0);
        chk("stl_rdv",   {48'd0, tr_rdv},  64'h01C8);
        chk("stl_done",  {48'd0, tr_done}, 64'h2000);
        chk("stl_req",   {48'd0, tr_req},  64'h1FFE);
        chk("stl_addr3", {48'd0, tr_addr[3]}, 64'h0201);
        chk("stl_addr4", {48'd0, tr_addr[4]}, 64'h0201);
        chk("stl_addr5", {48'd0, tr_addr[5]}, 64'h0201);
        chk("stl_addr6", {48'd0, tr_addr[6]}, 64'h0202);
        chk("stl_addr7", {48'd0, tr_addr[7]}, 64'h0203);
        chk("stl_rd4",   {32'd0, tr_rd[4]}, 64'h1000_0000);
        chk("stl_rd6",   {32'd0, tr_rd[6]}, 64'h1000_0003);
        chk("stl_rd8",   {32'd0, tr_rd[8]}, 64'h1000_0005);

        // address wrap
        run_txn(1'b0, 1'b0, 16'hFFFE, 3'd2, 16'hFFFF, 32'h0, 1'b0, 16'h0);
        chk("wrap_a0",   {48'd0, tr_addr[2]}, 64'hFFFE);
        chk("wrap_a1",   {48'd0, tr_addr[3]}, 64'hFFFF);
        chk("wrap_a2",   {48'd0, tr_addr[4]}, 64'h0000);
        chk("wrap_hold", {48'd0, tr_addr[5]}, 64'h0000);
        chk("wrap_done", {48'd0, tr_done},    64'h0400);

        // reset in the middle of a transfer
        sel_q = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_rdy", {63'd0, m_rdy}, 64'd1);
        cv  = 1'b1;
        cw  = 1'b0;
        ca  = 16'h0300;
        cl  = 3'd3;
        gnt = 1'b1;
        repeat (3) @(negedge clk);
        cv = 1'b0;
        #1;
        chk("rst_mid_busy", {62'd0, m_req, m_oe}, 64'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {57'd0, m_rdy, m_req, m_oe, m_we, m_wrr, m_rdv, m_done}, 64'd0);
        chk("rst_mid_data",  {m_rd, m_addr, m_wd[15:0]}, 64'd0);
        @(negedge clk); #1;
        chk("rst_mid_done", {63'd0, m_done}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_rdy0", {63'd0, m_rdy}, 64'd0);
        @(negedge clk); #1;
        chk("rst_rel_rdy1",  {63'd0, m_rdy}, 64'd1);
        chk("rst_rel_done",  {63'd0, m_done}, 64'd0);
        run_txn(1'b0, 1'b0, 16'h0050, 3'd0, 16'hFFFF, 32'h5555_AAAA, 1'b0, 16'h0);
        chk("post_rst_rdv",  {48'd0, tr_rdv},  64'h0008);
        chk("post_rst_done", {48'd0, tr_done}, 64'h0100);
        chk("post_rst_data", {32'd0, tr_rd[3]}, 64'h5555_AAAA);

        // HOLD_CYC = 0 build, second command accepted in the done cycle
        run_txn(1'b1, 1'b0, 16'h0040, 3'd0, 16'hFFFF, 32'h0BAD_F00D, 1'b1, 16'h0041);
        chk("h0_done",  {48'd0, tr_done}, 64'h0048);
        chk("h0_req",   {48'd0, tr_req},  64'h0036);
        chk("h0_rdv",   {48'd0, tr_rdv},  64'h0048);
        chk("h0_rdy",   {48'd0, tr_rdy},  64'hFFC9);
        chk("h0_addr0", {48'd0, tr_addr[2]}, 64'h0040);
        chk("h0_addr1", {48'd0, tr_addr[5]}, 64'h0041);
        chk("h0_rd1",   {32'd0, tr_rd[3]}, 64'h0BAD_F00D);
        chk("h0_rd2",   {32'd0, tr_rd[6]}, 64'h0BAD_F010);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
